// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with per-owner hold limit and one-hot registered grant.
// Ports: clock, reset (sync, active-high), req[N], gnt[N], gnt_valid, gnt_id[3], any_req.

module or8way (
    input  logic [7:0] a,
    output logic       y
);
    logic [3:0] l1;
    logic [1:0] l2;

    assign l1 = a[7:4] | a[3:0];
    assign l2 = l1[3:2] | l1[1:0];
    assign y  = l2[1] | l2[0];
endmodule

module rr_arbiter8 #(
    parameter int N        = 8,
    parameter int HOLD_MAX = 4,
    parameter int CW       = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [2:0]   gnt_id,
    output logic         any_req
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CW-1:0] HM1 =
        CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    state_t        state;
    logic [2:0]    ptr;
    logic [CW-1:0] hold_cnt;

    logic [N-1:0]  others;
    logic [2:0]    nxt;
    logic [2:0]    sel_idle;
    logic [2:0]    sel_next;
    logic          rel;
    logic          preempt;

    generate
        if (N == 8) begin : g_or8
            or8way u_or (
                .a (req),
                .y (any_req)
            );
        end else begin : g_orn
            assign any_req = |req;
        end
    endgenerate

    // First requester at or after s, cyclically.
    // Scanning backwards lets the closest hit win.
    function automatic logic [2:0] search(
        input logic [N-1:0] r,
        input logic [2:0]   s
    );
        logic [2:0] idx;
        search = 3'd0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = 3'((int'(s) + k) % N);
            if (r[idx]) search = idx;
        end
    endfunction

    always_comb begin
        others   = req & ~gnt;
        nxt      = (gnt_id == 3'(N - 1)) ? 3'd0 : gnt_id + 3'd1;
        rel      = ~req[gnt_id];
        preempt  = (HOLD_MAX != 0) && (hold_cnt == HM1) && (|others);
        sel_idle = search(req, ptr);
        // Owner bit is excluded, so on preemption the old
        // owner can only come back after everyone else.
        sel_next = search(others, nxt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= 3'd0;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt       <= N'(1) << sel_idle;
                        gnt_id    <= sel_idle;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        ptr      <= nxt;
                        hold_cnt <= '0;
                        if (|others) begin
                            gnt    <= N'(1) << sel_next;
                            gnt_id <= sel_next;
                        end else begin
                            gnt       <= '0;
                            gnt_id    <= 3'd0;
                            gnt_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (preempt) begin
                        ptr      <= nxt;
                        hold_cnt <= '0;
                        gnt      <= N'(1) << sel_next;
                        gnt_id   <= sel_next;
                    end else if (HOLD_MAX != 0 && hold_cnt != HM1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: directed scenarios plus random traffic
// checked against a cycle-level ownership model.

module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req   = 8'h00;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_id;
    logic       any_req;

    int checks   = 0;
    int failures = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;

    rr_arbiter8 #(.N(8), .HOLD_MAX(HOLD), .CW(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .any_req   (any_req)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int msearch(input logic [7:0] r, input int s);
        for (int k = 0; k < 8; k++) begin
            if (r[(s + k) % 8]) return (s + k) % 8;
        end
        return -1;
    endfunction

    // Ownership model: m_held counts cycles the owner has held
    // the grant, including the cycle it was won.
    task automatic model_edge();
        logic [7:0] oth;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            if (req != 0) begin
                m_owner = msearch(req, m_ptr);
                m_held  = 1;
            end
        end else begin
            oth = req;
            oth[m_owner] = 1'b0;
            if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = (oth != 0) ? msearch(oth, m_ptr) : -1;
                m_held  = 1;
            end else if (m_held >= HOLD && oth != 0) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = msearch(oth, m_ptr);
                m_held  = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic step();
        logic [7:0] eg;
        model_edge();
        @(posedge clock);
        #1;
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("gnt_id", 32'(gnt_id), (m_owner < 0) ? 0 : 32'(m_owner));
        chk("any_req", 32'(any_req), 32'(req != 0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset with all requests active
        req = 8'hFF;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_gnt", 32'(gnt), 0);
        end
        reset = 1'b0;

        // 2: idle then single request, 1-cycle latency
        req = 8'h00;
        for (int i = 0; i < 5; i++) step();
        req = 8'h10;
        #1;
        chk("anyreq_comb", 32'(any_req), 1);
        chk("gnt_before", 32'(gnt), 0);
        step();
        chk("t2_gnt", 32'(gnt), 32'h10);
        chk("t2_id", 32'(gnt_id), 4);

        // 3: all requesting, 4 cycles each in order
        do_reset();
        req = 8'hFF;
        for (int o = 0; o <= 8; o++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                chk("t3_rotate", 32'(gnt_id), 32'(o % 8));
            end
        end

        // 4: release-driven handoffs
        do_reset();
        req = 8'h10;
        step();
        req = 8'b00100110;
        step();
        chk("t4_a", 32'(gnt_id), 5);
        req = 8'b00000110;
        step();
        chk("t4_b", 32'(gnt_id), 1);
        req = 8'b00000100;
        step();
        chk("t4_c", 32'(gnt_id), 2);
        req = 8'h00;
        step();
        chk("t4_idle", 32'(gnt_valid), 0);

        // 5: lone requester keeps grant, then immediate switch
        do_reset();
        req = 8'h01;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_hold", 32'(gnt_id), 0);
        end
        req = 8'h09;
        step();
        chk("t5_switch", 32'(gnt_id), 3);

        // 6: reset mid-grant, pointer back to 0
        do_reset();
        req = 8'h40;
        step();
        req = 8'hC1;
        step();
        chk("t6_own", 32'(gnt_id), 6);
        reset = 1'b1;
        step();
        chk("t6_rst", 32'(gnt), 0);
        reset = 1'b0;
        step();
        chk("t6_after", 32'(gnt_id), 0);

        // random traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0)
                req = req ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
